// File: rtl/cordic_angle_sequencer.sv
// Folds full-circle angle requests into the CORDIC core's +/-90 deg range, launches the core, sign-corrects its result.
// Latency: RESET_CYCLES + N_core + 1 cycles from acceptance to out_valid_o (RESET_CYCLES + TIMEOUT_CYCLES + 1 on timeout).
// Backpressure: one request in flight; in_ready_o stays low until the result is taken, out_ready_o low holds the result.
module cordic_angle_sequencer #(
   parameter int RESET_CYCLES   = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic signed [31:0] in_angle_i,
   output logic signed [31:0] core_angle_o,
   output logic               core_reset_o,
   input  logic               core_done_i,
   input  logic signed [15:0] core_sin_i,
   input  logic signed [15:0] core_cos_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic signed [15:0] out_sin_o,
   output logic signed [15:0] out_cos_o,
   output logic               out_err_o
);

   // One counter serves both the launch pulse and the RUN timeout.
   localparam int CNT_MAX = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1) + 1;

   localparam logic signed [32:0] QUARTER = 33'sd1073741824;  //  90 deg
   localparam logic signed [32:0] HALF    = 33'sd2147483648;  // 180 deg

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_OUT
   } state_t;

   state_t               state_q;
   logic                 in_ready_q;
   logic                 core_reset_q;
   logic signed [31:0]   angle_q;
   logic                 flip_q;
   logic                 out_valid_q;
   logic signed [15:0]   out_sin_q;
   logic signed [15:0]   out_cos_q;
   logic                 out_err_q;
   logic [CW-1:0]        cnt_q;

   logic signed [32:0]   ext_angle;
   logic signed [32:0]   red_angle;
   logic signed [31:0]   angle_d;
   logic                 flip_d;
   logic signed [15:0]   cos_d;

   // Fold the incoming angle into [-90, 90] deg; angles beyond that mirror about +/-90 and flip cos.
   always_comb begin
      ext_angle = {in_angle_i[31], in_angle_i};
      red_angle = ext_angle;
      flip_d    = 1'b0;
      if (ext_angle > QUARTER) begin
         red_angle = HALF - ext_angle;
         flip_d    = 1'b1;
      end else if (ext_angle < -QUARTER) begin
         red_angle = -HALF - ext_angle;
         flip_d    = 1'b1;
      end
      angle_d = red_angle[31:0];
   end

   // Quadrant correction of cos; -1.0 negates to the largest positive code instead of wrapping.
   always_comb begin
      cos_d = core_cos_i;
      if (flip_q) begin
         cos_d = (core_cos_i == 16'sh8000) ? 16'sh7FFF : -core_cos_i;
      end
   end

   // Sequencer FSM with all outputs registered; core stays held in reset while idle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b0;
         core_reset_q <= 1'b1;
         angle_q      <= '0;
         flip_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sin_q    <= '0;
         out_cos_q    <= '0;
         out_err_q    <= 1'b0;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               core_reset_q <= 1'b1;
               if (in_ready_q && in_valid_i) begin
                  state_q    <= S_LAUNCH;
                  in_ready_q <= 1'b0;
                  angle_q    <= angle_d;
                  flip_q     <= flip_d;
                  cnt_q      <= '0;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            S_LAUNCH: begin
               if (cnt_q == CW'(RESET_CYCLES - 1)) begin
                  state_q      <= S_RUN;
                  core_reset_q <= 1'b0;
                  cnt_q        <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RUN: begin
               if (core_done_i) begin
                  state_q     <= S_OUT;
                  out_valid_q <= 1'b1;
                  out_sin_q   <= core_sin_i;
                  out_cos_q   <= cos_d;
                  out_err_q   <= 1'b0;
               end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                  state_q     <= S_OUT;
                  out_valid_q <= 1'b1;
                  out_sin_q   <= '0;
                  out_cos_q   <= '0;
                  out_err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_OUT: begin
               if (out_ready_i) begin
                  state_q      <= S_IDLE;
                  out_valid_q  <= 1'b0;
                  in_ready_q   <= 1'b1;
                  core_reset_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready_o   = in_ready_q;
   assign core_reset_o = core_reset_q;
   assign core_angle_o = angle_q;
   assign out_valid_o  = out_valid_q;
   assign out_sin_o    = out_sin_q;
   assign out_cos_o    = out_cos_q;
   assign out_err_o    = out_err_q;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Bench for cordic_angle_sequencer: behavioural core model, scoreboard queues, decoupled output monitor.
// Checks reduction, sign correction, latency, timeout, backpressure stability and asynchronous reset.
// Output readiness is randomised, with a forced 10-cycle stall on the timeout transaction.
module tb_cordic_angle_sequencer;

   localparam int R = 2;
   localparam int T = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_angle;
   logic [31:0] core_angle;
   logic        core_reset;
   logic        core_done;
   logic [15:0] core_sin;
   logic [15:0] core_cos;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sin;
   logic [15:0] out_cos;
   logic        out_err;

   cordic_angle_sequencer #(.RESET_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_angle_i   (in_angle),
      .core_angle_o (core_angle),
      .core_reset_o (core_reset),
      .core_done_i  (core_done),
      .core_sin_i   (core_sin),
      .core_cos_i   (core_cos),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_sin_o    (out_sin),
      .out_cos_o    (out_cos),
      .out_err_o    (out_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // scoreboard
   logic [31:0] q_angle[$];
   logic [15:0] q_sin[$];
   logic [15:0] q_cos[$];
   logic        q_err[$];
   int          q_lat[$];
   int          q_acc[$];

   // per-transaction core behaviour
   int          cur_n    = 0;
   bit          cur_hang = 1'b0;
   logic [15:0] cur_sin  = '0;
   logic [15:0] cur_cos  = '0;
   int          hold_n   = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: fold the angle with plain integer arithmetic, mirror cos when folded, clamp +32768.
   function automatic void ref_model(input logic [31:0] a, input logic [15:0] cs, input logic [15:0] cc,
                                     output logic [31:0] ca, output logic [15:0] es, output logic [15:0] ec);
      longint av;
      longint r;
      longint c;
      bit     flip;
      av   = longint'($signed(a));
      flip = 1'b0;
      r    = av;
      if (av > 64'sd1073741824) begin
         r = 64'sd2147483648 - av;
         flip = 1'b1;
      end else if (av < -64'sd1073741824) begin
         r = -64'sd2147483648 - av;
         flip = 1'b1;
      end
      c = longint'($signed(cc));
      if (flip) c = -c;
      if (c > 32767) c = 32767;
      ca = r[31:0];
      es = cs;
      ec = c[15:0];
   endfunction

   task automatic issue(input logic [31:0] a, input logic [15:0] s, input logic [15:0] c,
                        input int n, input bit hang, input int hold);
      int w;
      logic [31:0] ca;
      logic [15:0] es;
      logic [15:0] ec;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 1000) begin
         in_valid = 1'($urandom_range(0, 1));
         in_angle = $urandom;
         @(negedge clk);
         w++;
      end
      if (w >= 1000) begin
         chk("in_ready_wait_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      cur_n = n; cur_hang = hang; cur_sin = s; cur_cos = c; hold_n = hold;
      ref_model(a, s, c, ca, es, ec);
      q_angle.push_back(ca);
      q_sin.push_back(hang ? 16'h0 : es);
      q_cos.push_back(hang ? 16'h0 : ec);
      q_err.push_back(hang);
      q_lat.push_back(hang ? (R + T + 1) : (R + n + 1));
      in_angle = a;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      q_acc.push_back(cyc);
      in_valid = 1'b0;
      in_angle = $urandom;
   endtask

   // Core model: done rises n cycles after leaving reset and holds until the next reset.
   int ccnt = 0;
   bit prev_cr = 1'b1;
   initial begin
      core_done = 1'b0;
      core_sin  = '0;
      core_cos  = '0;
      forever begin
         @(negedge clk);
         if (core_reset) begin
            ccnt = 0;
            core_done = 1'b0;
            core_sin = 16'($urandom);
            core_cos = 16'($urandom);
         end else begin
            if (prev_cr) begin
               if (q_angle.size() == 0) chk("core_start_unexpected", 1, 0);
               else chk("core_angle", core_angle, q_angle.pop_front());
            end
            ccnt++;
            if (!core_done) begin
               if (!cur_hang && ccnt > cur_n) begin
                  core_done = 1'b1;
                  core_sin = cur_sin;
                  core_cos = cur_cos;
               end else begin
                  core_sin = 16'($urandom);
                  core_cos = 16'($urandom);
               end
            end
         end
         prev_cr = core_reset;
      end
   end

   // Output monitor: pops on new output, checks stability while held, checks handshake aftermath.
   bit          holding = 1'b0;
   bit          hs_prev = 1'b0;
   logic [15:0] h_sin, h_cos;
   logic        h_err;
   initial begin
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            holding = 1'b0;
            hs_prev = 1'b0;
         end else begin
            if (hs_prev) begin
               chk("hs_out_valid_low", out_valid, 0);
               chk("hs_in_ready_high", in_ready, 1);
               holding = 1'b0;
            end
            hs_prev = 1'b0;
            if (out_valid) begin
               chk("busy_in_ready", in_ready, 0);
               if (!holding) begin
                  if (q_sin.size() == 0 || q_acc.size() == 0) begin
                     chk("unexpected_output", 1, 0);
                  end else begin
                     chk("out_sin", out_sin, q_sin.pop_front());
                     chk("out_cos", out_cos, q_cos.pop_front());
                     chk("out_err", out_err, q_err.pop_front());
                     chk("latency", cyc - q_acc.pop_front(), q_lat.pop_front());
                  end
                  h_sin = out_sin; h_cos = out_cos; h_err = out_err;
                  holding = 1'b1;
               end else begin
                  chk("hold_sin", out_sin, h_sin);
                  chk("hold_cos", out_cos, h_cos);
                  chk("hold_err", out_err, h_err);
               end
               if (hold_n > 0) begin
                  out_ready = 1'b0;
                  hold_n--;
               end else begin
                  out_ready = ($urandom_range(0, 3) != 0);
               end
               hs_prev = out_ready;
            end else begin
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},   in_ready, 0);
      chk({tag, "_core_reset"}, core_reset, 1);
      chk({tag, "_core_angle"}, core_angle, 0);
      chk({tag, "_out_valid"},  out_valid, 0);
      chk({tag, "_out_sin"},    out_sin, 0);
      chk({tag, "_out_cos"},    out_cos, 0);
      chk({tag, "_out_err"},    out_err, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a;
      logic [15:0] s;
      logic [15:0] c;
      int          n;
      bit          hang;
      int          hold;
   } vec_t;

   vec_t dir[$];

   initial begin
      int w;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_angle = '0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1 chk("por_release_in_ready", in_ready, 0);
      @(posedge clk); #1 chk("por_first_edge_in_ready", in_ready, 1);

      // Reset mid-RUN with a hung core: request must vanish without output.
      issue(32'h20000000, 16'd11585, 16'd11585, 0, 1'b1, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_core_reset", core_reset, 1);
      chk("midrst_in_ready", in_ready, 0);
      q_angle.delete(); q_sin.delete(); q_cos.delete();
      q_err.delete(); q_lat.delete(); q_acc.delete();
      cur_hang = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst_held");
      reset = 1'b0;
      #1 chk("midrst_release_in_ready", in_ready, 0);
      @(posedge clk); #1 chk("midrst_edge_in_ready", in_ready, 1);

      dir.push_back('{32'h20000000, 16'd11585,  16'd11585, 3, 1'b0, 0});
      dir.push_back('{32'h60000000, 16'd11585,  16'd11585, 5, 1'b0, 0});
      dir.push_back('{32'hA0000000, 16'hD2BF,   16'd11585, 0, 1'b0, 0});
      dir.push_back('{32'h40000000, 16'd7,      16'd100,   2, 1'b0, 0});
      dir.push_back('{32'h40000001, 16'd5,      16'd200,   1, 1'b0, 0});
      dir.push_back('{32'h80000000, 16'd0,      16'd16384, 4, 1'b0, 0});
      dir.push_back('{32'h70000000, 16'd1234,   16'h8000,  2, 1'b0, 0});
      dir.push_back('{32'hC0000000, 16'hC000,   16'h8000,  1, 1'b0, 0});
      dir.push_back('{32'h12345678, 16'd999,    16'd999,   0, 1'b1, 10});
      foreach (dir[i]) issue(dir[i].a, dir[i].s, dir[i].c, dir[i].n, dir[i].hang, dir[i].hold);

      for (int i = 0; i < 60; i++) begin
         logic [15:0] rc;
         rc = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
         issue($urandom, 16'($urandom), rc, int'($urandom_range(0, 8)),
               ($urandom_range(0, 15) == 0), 0);
      end

      w = 0;
      while ((q_sin.size() != 0 || out_valid) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 2000) chk("drain_timeout", 0, 1);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cordic_angle_sequencer.md
# cordic_angle_sequencer

Front-end stage that sits directly upstream of the CORDIC sin/cos core. It accepts full-circle angle requests over a valid/ready handshake and folds each angle into the core's ±90° range. It launches the core by pulsing its reset, waits for `done`, applies the quadrant sign correction to the core's sin/cos results, and presents them downstream with a timeout guard. One request is in flight at a time.

## Interface
- `RESET_CYCLES`, default 1: number of cycles `core_reset` is held high to launch a computation (≥1).
- `TIMEOUT_CYCLES`, default 64: maximum number of RUN cycles to wait for `core_done` before flagging an error.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request (registered).
- `in_angle` in 32 signed: angle, 2^30 = 90°; the full 32-bit range covers [-180°, 180°).
- `core_angle` out 32 signed: reduced angle to the core, always in [-2^30, 2^30].
- `core_reset` out 1: core reset/start; while high, the core is cleared.
- `core_done` in 1: core result valid; held high until the next `core_reset`.
- `core_sin`, `core_cos` in 16 signed: core outputs, Q2.14 (16384 = 1.0).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_sin`, `out_cos` out 16 signed: corrected results, Q2.14.
- `out_err` out 1: qualifies `out_valid`; 1 = core timeout, results forced to 0.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, go to LAUNCH.
  - LAUNCH: `core_reset`=1 for RESET_CYCLES cycles, then go to RUN.
  - RUN: `core_reset`=0. On `core_done` go to OUT. If the timeout counter reaches TIMEOUT_CYCLES, go to OUT with error.
  - OUT: `out_valid`=1. On `out_ready`, go to IDLE.
- Reduction is computed at acceptance in 33-bit arithmetic; `core_angle` and the `flip` flag are registered:
  - -2^30 ≤ a ≤ 2^30: `core_angle`=a, flip=0.
  - a > 2^30: `core_angle`=2^31−a, flip=1.
  - a < -2^30: `core_angle`=−2^31−a, flip=1.
- Correction: `out_sin`=`core_sin` unchanged. `out_cos`=flip ? −`core_cos` : `core_cos`. Negating −32768 saturates to +32767.
- On timeout: `out_err`=1, `out_sin`=`out_cos`=0.
- `core_done` is ignored while `core_reset`=1 and in every state other than RUN.
- `out_sin`, `out_cos`, `out_err` are stable for as long as `out_valid`=1; `out_ready` low holds them indefinitely.
- `in_valid` while not IDLE is ignored, because `in_ready`=0.

## Timing
- Reset values (held while `reset`=1):
  - state IDLE.
  - `in_ready`=0, then 1 at the first rising edge after `reset` falls.
  - `core_reset`=1, `core_angle`=0.
  - `out_valid`=0, `out_sin`=`out_cos`=0, `out_err`=0.
  - timeout counter 0.
- Acceptance at edge E0. From E0+1, `in_ready`=0, `core_reset`=1, and `core_angle` holds the reduced value.
- `core_reset` falls at edge E0+RESET_CYCLES. RUN begins that cycle and the timeout counter starts at 0.
- The first RUN edge with `core_done`=1 samples `core_sin`/`core_cos`. `out_valid`=1 from the next cycle.
- Latency from acceptance to `out_valid` = RESET_CYCLES + N_core + 1 cycles, where N_core is the number of RUN cycles until `done`.
- Timeout: if `core_done` is still 0 after TIMEOUT_CYCLES RUN cycles, `out_valid`=1 and `out_err`=1 from the next cycle.
- In OUT, `core_reset` stays 0 and `core_angle` holds its value.
- Output handshake at edge E1 (`out_valid`&&`out_ready`): `out_valid`=0 and `in_ready`=1 from E1+1. Back-to-back acceptance is possible at E1+1.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously). Any in-flight request is dropped and no `out_valid` is produced for it.

## Test plan
- Reset mid-RUN: accept 0x20000000, assert `reset` 3 cycles later -> `out_valid`=0, `core_reset`=1, `in_ready`=0 immediately; `in_ready`=1 one edge after release; no stale output appears.
- 45° (`in_angle`=0x20000000) -> `core_angle`=0x20000000, flip=0; with a core model returning sin=cos=11585 -> `out_sin`=11585, `out_cos`=11585, `out_err`=0; `out_valid` exactly RESET_CYCLES+N_core+1 cycles after acceptance.
- 135° (0x60000000) -> `core_angle`=0x20000000; core returns 11585/11585 -> `out_sin`=11585, `out_cos`=−11585.
- −135° (0xA0000000) -> `core_angle`=0xE0000000; core returns −11585/11585 -> `out_sin`=−11585, `out_cos`=−11585.
- Boundaries:
  - 0x40000000 -> `core_angle`=0x40000000, flip=0.
  - 0x40000001 -> `core_angle`=0x3FFFFFFF, flip=1.
  - 0x80000000 (−180°) -> `core_angle`=0; core returns cos=16384 -> `out_cos`=−16384.
  - core returns cos=−32768 with flip=1 -> `out_cos`=32767.
- Timeout and backpressure: `core_done` held 0 -> `out_valid`=1 with `out_err`=1 and zeros exactly TIMEOUT_CYCLES+1 cycles after RUN entry. Hold `out_ready`=0 for 10 cycles -> outputs stable and `in_ready`=0 throughout; `out_ready`=1 -> `in_ready`=1 on the next cycle.
